hamming_tx_arbiter: RTL and testbench

HAMMING_TX_ARBITER -- requirements
Module: hamming_tx_arbiter

---
 rtl/hamming_tx_arbiter_pkg.sv | 11 +
 rtl/hamming_tx_arbiter_if.sv | 28 ++
 rtl/hamming_tx_arbiter_encoder.sv | 25 ++
 rtl/hamming_tx_arbiter.sv | 97 +++++++++
 tb/tb_hamming_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hamming_tx_arbiter_pkg.sv
// Shared Hamming parameters and FSM state encoding for the serial Hamming transmitter.
package hamming_pkg;
  localparam int P_DEF = 3;
  localparam int N_DEF = (2 ** P_DEF) - 1;
  localparam int K_DEF = (2 ** P_DEF) - P_DEF - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/hamming_tx_arbiter_if.sv
// Requester handshakes and serial transmit bus of the Hamming arbiter.
interface hamming_tx_arbiter_if import hamming_pkg::*; #(
  parameter int P = P_DEF
);
  localparam int K = (2 ** P) - P - 1;

  logic         a_valid;
  logic [K-1:0] a_data;
  logic         a_ready;
  logic         b_valid;
  logic [K-1:0] b_data;
  logic         b_ready;
  logic         tx_bit;
  logic         tx_valid;
  logic         tx_last;
  logic         tx_src;
  logic         busy;

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, tx_bit, tx_valid, tx_last, tx_src, busy
  );

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, tx_bit, tx_valid, tx_last, tx_src, busy
  );
endinterface

// File: rtl/hamming_tx_arbiter_encoder.sv
// Combinational Hamming encoder: data word in the upper bits, parity bits below.
module hamming_7_4_encoder import hamming_pkg::*; #(
  parameter int P = P_DEF,
  localparam int N = (2 ** P) - 1,
  localparam int K = (2 ** P) - P - 1
) (
  input  logic [K-1:0] data,
  output logic [N-1:0] msg
);

  if (P == 3) begin : g_h74
    always_comb begin
      msg      = '0;
      msg[6:3] = data[3:0];
      msg[2]   = data[3] ^ data[2] ^ data[1];
      msg[1]   = data[3] ^ data[2] ^ data[0];
      msg[0]   = data[3] ^ data[1] ^ data[0];
    end
  end else begin : g_unsupported
    // The parity map is only defined for the (7,4) code.
    $error("hamming_7_4_encoder supports P=3 only");
    assign msg = '0;
  end

endmodule

// File: rtl/hamming_tx_arbiter.sv
// Two-requester round-robin arbiter feeding a Hamming(7,4) serialiser, MSB first.
module hamming_tx_arbiter import hamming_pkg::*; #(
  parameter int P = P_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming_tx_arbiter_if.slave  bus
);

  localparam int N  = (2 ** P) - 1;
  localparam int K  = (2 ** P) - P - 1;
  localparam int CW = $clog2(N);

  state_e         state_q, state_d;
  logic [N-1:0]   sr_q, sr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           src_q, src_d;
  logic           last_b_q, last_b_d;

  logic           idle, shifting, last_bit;
  logic           gnt_a, gnt_b;
  logic [K-1:0]   enc_data;
  logic [N-1:0]   enc_msg;

  assign idle     = (state_q == IDLE);
  assign shifting = (state_q == SHIFT);
  assign last_bit = shifting && (cnt_q == CW'(N - 1));

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    gnt_a = bus.a_valid && (!bus.b_valid || last_b_q);
    gnt_b = bus.b_valid && (!bus.a_valid || !last_b_q);
  end

  assign bus.a_ready = idle && gnt_a;
  assign bus.b_ready = idle && gnt_b;

  assign enc_data = gnt_b ? bus.b_data : bus.a_data;

  hamming_7_4_encoder #(.P(P)) u_enc (
    .data (enc_data),
    .msg  (enc_msg)
  );

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    src_d    = src_q;
    last_b_d = last_b_q;
    case (state_q)
      IDLE: begin
        if (gnt_a || gnt_b) begin
          sr_d     = enc_msg;
          src_d    = gnt_b;
          last_b_d = gnt_b;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        sr_d = {sr_q[N-2:0], 1'b0};
        if (last_bit) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // last_b resets high so that A wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      cnt_q    <= '0;
      src_q    <= 1'b0;
      last_b_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      src_q    <= src_d;
      last_b_q <= last_b_d;
    end
  end

  assign bus.tx_valid = shifting;
  assign bus.tx_bit   = shifting && sr_q[N-1];
  assign bus.tx_last  = last_bit;
  assign bus.tx_src   = src_q;
  assign bus.busy     = !idle;

endmodule

// File: tb/tb_hamming_tx_arbiter.sv
// Self-checking bench: frame vector table, directed corner sequences, random traffic vs a queue model.
module tb_hamming_tx_arbiter;
  localparam int P = 3;
  localparam int N = 7;
  localparam int K = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  hamming_tx_arbiter_if #(.P(P)) bus ();

  hamming_tx_arbiter #(.P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Parity from bit counts, straight from the code definition.
  function automatic logic [N-1:0] ref_encode(input logic [K-1:0] d);
    int p2, p1, p0;
    p2 = (int'(d[3]) + int'(d[2]) + int'(d[1])) % 2;
    p1 = (int'(d[3]) + int'(d[2]) + int'(d[0])) % 2;
    p0 = (int'(d[3]) + int'(d[1]) + int'(d[0])) % 2;
    return {d, p2[0], p1[0], p0[0]};
  endfunction

  // Model: a queue of bits still to send; empty queue means idle.
  bit mq[$];
  bit m_src   = 1'b0;
  bit m_lastb = 1'b1;
  bit chk_en  = 1'b0;

  typedef struct {
    logic [N-1:0] frame;
    logic         src;
  } obs_t;
  obs_t         obs[$];
  logic [N-1:0] cur = '0;
  int           nbits = 0;

  always @(negedge clk) begin
    logic         ea, eb, wa, wb;
    logic [6:0]   e, a;
    logic [N-1:0] w;
    wa = bus.a_valid && !(bus.b_valid && !m_lastb);
    wb = bus.b_valid && !(bus.a_valid && m_lastb);
    ea = (mq.size() == 0) && wa;
    eb = (mq.size() == 0) && wb;
    if (chk_en) begin
      e = {ea, eb, mq.size() != 0, (mq.size() != 0) ? mq[0] : 1'b0,
           mq.size() == 1, m_src, mq.size() != 0};
      a = {bus.a_ready, bus.b_ready, bus.tx_valid, bus.tx_bit,
           bus.tx_last, bus.tx_src, bus.busy};
      check("cycle", 32'(a), 32'(e));
      check("ready_excl", 32'(bus.a_ready && bus.b_ready), 32'd0);
    end
    if (!rst) begin
      nbits = 0;
    end else if (bus.tx_valid === 1'b1) begin
      cur = {cur[N-2:0], bus.tx_bit};
      nbits++;
      if (bus.tx_last === 1'b1) begin
        check("frame_len", 32'(nbits), 32'(N));
        obs.push_back('{cur, bus.tx_src});
        nbits = 0;
      end
    end
    if (!rst) begin
      mq.delete();
      m_src   = 1'b0;
      m_lastb = 1'b1;
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end else if (wa || wb) begin
      w = ref_encode(wb ? bus.b_data : bus.a_data);
      for (int i = N - 1; i >= 0; i--) mq.push_back(w[i]);
      m_src   = wb;
      m_lastb = wb;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic av, input logic [K-1:0] ad, input logic bv, input logic [K-1:0] bd);
    bus.a_valid = av;
    bus.a_data  = ad;
    bus.b_valid = bv;
    bus.b_data  = bd;
  endtask

  task automatic wait_hs;
    bit ok = 1'b0;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      #1;
      if ((bus.a_valid && bus.a_ready) || (bus.b_valid && bus.b_ready)) begin
        ok = 1'b1;
        break;
      end
    end
    check("hs_timeout", 32'(ok), 32'd1);
    tick();
  endtask

  task automatic wait_frames(input int n);
    for (int g = 0; g < 200 && obs.size() < n; g++) begin
      @(negedge clk);
      #1;
    end
    check("frame_timeout", 32'(obs.size() >= n), 32'd1);
    tick();
  endtask

  task automatic wait_idle;
    for (int g = 0; g < 40; g++) begin
      @(negedge clk);
      #1;
      if (bus.busy === 1'b0) break;
    end
    tick();
  endtask

  task automatic do_reset;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  typedef struct {
    logic         av;
    logic [K-1:0] ad;
    logic         bv;
    logic [K-1:0] bd;
    logic         xsrc;
    logic [N-1:0] xf;
  } vec_t;
  vec_t vecs[5];

  logic [N-1:0] alt_f[4];
  logic         alt_s[4];

  initial begin
    int base;
    vecs[0] = '{1'b1, 4'b0011, 1'b0, 4'b0000, 1'b0, 7'b0011110};
    vecs[1] = '{1'b0, 4'b0000, 1'b1, 4'b1111, 1'b1, 7'b1111111};
    vecs[2] = '{1'b0, 4'b0000, 1'b1, 4'b0111, 1'b1, 7'b0111000};
    vecs[3] = '{1'b1, 4'b0110, 1'b1, 4'b1000, 1'b0, 7'b0110011};
    vecs[4] = '{1'b1, 4'b0110, 1'b1, 4'b1000, 1'b1, 7'b1000111};
    alt_f   = '{7'b1010010, 7'b1001100, 7'b1010010, 7'b1001100};
    alt_s   = '{1'b0, 1'b1, 1'b0, 1'b1};

    drive(1'b0, '0, 1'b0, '0);
    tick(); tick(); tick();
    chk_en = 1'b1;
    rst    = 1'b1;
    @(negedge clk);
    check("rst_idle", 32'({bus.tx_valid, bus.tx_bit, bus.tx_last, bus.busy, bus.tx_src}), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      base = obs.size();
      drive(vecs[i].av, vecs[i].ad, vecs[i].bv, vecs[i].bd);
      wait_hs();
      drive(1'b0, '0, 1'b0, '0);
      wait_frames(base + 1);
      if (obs.size() > base) begin
        check($sformatf("vec%0d_frame", i), 32'(obs[base].frame), 32'(vecs[i].xf));
        check($sformatf("vec%0d_src", i), 32'(obs[base].src), 32'(vecs[i].xsrc));
      end
      wait_idle();
    end

    // Ties held for four frames alternate A, B, A, B.
    do_reset();
    base = obs.size();
    drive(1'b1, 4'b1010, 1'b1, 4'b1001);
    wait_frames(base + 4);
    drive(1'b0, '0, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      if (obs.size() > base + i) begin
        check($sformatf("alt%0d_frame", i), 32'(obs[base+i].frame), 32'(alt_f[i]));
        check($sformatf("alt%0d_src", i), 32'(obs[base+i].src), 32'(alt_s[i]));
      end
    end
    wait_idle();

    // Inputs changing mid-frame must not be captured or acknowledged.
    base = obs.size();
    drive(1'b1, 4'b0011, 1'b0, '0);
    wait_hs();
    drive(1'b1, 4'b1111, 1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_ready", 32'({bus.a_ready, bus.b_ready}), 32'd0);
      tick();
    end
    wait_frames(base + 1);
    drive(1'b0, '0, 1'b0, '0);
    if (obs.size() > base) begin
      check("mid_frame", 32'(obs[base].frame), 32'(7'b0011110));
      check("mid_src", 32'(obs[base].src), 32'd0);
    end
    wait_idle();

    // Reset during the third bit aborts the frame and re-arms A priority.
    base = obs.size();
    drive(1'b0, '0, 1'b1, 4'b1111);
    wait_hs();
    drive(1'b0, '0, 1'b0, '0);
    tick();
    tick();
    rst = 1'b0;
    drive(1'b1, 4'b0101, 1'b1, 4'b1001);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("abort_idle", 32'({bus.tx_valid, bus.busy}), 32'd0);
    check("abort_gnt", 32'({bus.a_ready, bus.b_ready}), 32'b10);
    tick();
    drive(1'b0, '0, 1'b0, '0);
    wait_frames(base + 1);
    if (obs.size() > base) begin
      check("abort_frame", 32'(obs[base].frame), 32'(7'b0101101));
      check("abort_src", 32'(obs[base].src), 32'd0);
    end
    wait_idle();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) != 0);
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
      tick();
    end
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, '0);
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
